// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: streams sequential words from imem into a PC-tagged FIFO for decode.
// Optional macro FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic          ir_valid,
  output logic [15:0]   ir,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);

  logic [AW-1:0] fpc_q;
  logic [AW-1:0] infl_pc_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          infl_q, drop_q;
  logic [AW-1:0] pc_mem_q  [DEPTH];
  logic [15:0]   ins_mem_q [DEPTH];

  logic          q_nonempty, resp, bypass, push, pop;
  logic [CW:0]   credit;

  assign q_nonempty = (count_q != '0);
  assign resp       = infl_q && !drop_q;

  // Credit counts the outstanding read but not a same-cycle pop, so the queue can never overflow.
  assign credit    = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
  assign imem_en   = reset && !halt && !redir_valid && (credit < DepthC);
  assign imem_addr = fpc_q;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp && !q_nonempty;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = q_nonempty && ir_ready;
  assign push = resp && !(bypass && ir_ready);

  always_comb begin
    ir_valid = q_nonempty;
    ir       = ins_mem_q[rd_ptr_q];
    ir_pc    = pc_mem_q[rd_ptr_q];
    if (bypass) begin
      ir_valid = 1'b1;
      ir       = imem_rdata;
      ir_pc    = infl_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q     <= '0;
      infl_pc_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      infl_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      infl_q <= imem_en;
      if (imem_en) begin
        fpc_q     <= fpc_q + AW'(1);
        infl_pc_q <= fpc_q;
      end
      if (redir_valid) begin
        // Flush everything; a response arriving next cycle belongs to the old stream.
        fpc_q    <= redir_pc;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        drop_q   <= infl_q;
      end else begin
        drop_q <= 1'b0;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (!redir_valid && push) begin
      pc_mem_q[wr_ptr_q]  <= infl_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
